// File: rtl/fta_bus_pkg.sv
// FTA bus shared types.
//   fta_cmd_response128_t : response beat carried on every slave/master response channel.
//   fta_respbuf_arb_e     : arbitration policy selector for fta_respbuf_fifo.
package fta_bus_pkg;

    typedef struct packed {
        logic         ack;    // response valid
        logic         err;
        logic         rty;
        logic         stall;
        logic         next;
        logic [3:0]   pri;    // lower value = more urgent
        logic [5:0]   cid;
        logic [7:0]   tid;
        logic [31:0]  adr;
        logic [127:0] dat;
    } fta_cmd_response128_t;

    typedef enum logic [1:0] {
        FTA_ARB_RR    = 2'd0,
        FTA_ARB_FIXED = 2'd1,
        FTA_ARB_PRI   = 2'd2
    } fta_respbuf_arb_e;

endpackage

// File: rtl/fta_respbuf_fifo_pkg.sv
// Helpers for fta_respbuf_fifo.
//   PRI_IDLE          : pri value carried by an idle response.
//   resp_idle()       : the idle / reset value of the merged response port.
//   resp_from_entry() : turns a buffered entry into an outgoing response beat.
package fta_respbuf_fifo_pkg;
    import fta_bus_pkg::*;

    localparam logic [3:0] PRI_IDLE = 4'hF;

    function automatic fta_cmd_response128_t resp_idle();
        fta_cmd_response128_t r;
        r     = '0;
        r.pri = PRI_IDLE;
        return r;
    endfunction

    // Flow-control bits of the source are not forwarded; stall/next are
    // meaningless on the merged port.
    function automatic fta_cmd_response128_t resp_from_entry(input fta_cmd_response128_t e);
        fta_cmd_response128_t r;
        r       = e;
        r.ack   = 1'b1;
        r.stall = 1'b0;
        r.next  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/fta_respbuf_fifo_ch.sv
// One per-channel response FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO).
//   push, din  : write din (ack forced to 1) when push=1.
//   pop        : remove the head entry; ignored when empty.
//   dout       : head entry (valid when !empty).
//   empty/full : occupancy flags derived from the registered count.
//   ovf_clr    : clears the sticky ovf bit; a same-cycle drop keeps it set.
//   ovf        : sticky, a push was dropped because the FIFO was full.
module fta_respbuf_fifo_ch
    import fta_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 ovf_clr,
    input  fta_cmd_response128_t din,
    output fta_cmd_response128_t dout,
    output logic                 empty,
    output logic                 full,
    output logic                 ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fta_cmd_response128_t mem [DEPTH];
    fta_cmd_response128_t din_w;
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [CW-1:0]        count;
    logic                 wr_en;
    logic                 rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rptr];

    always_comb begin
        din_w     = din;
        din_w.ack = 1'b1;
    end

    // Storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= din_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !wr_en) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fta_respbuf_fifo.sv
// Multi-channel FTA response collector.
//   clk, rst_n : clock, asynchronous active-low reset.
//   resp[c]    : response from source c; buffered when resp[c].ack=1.
//   stall_i    : downstream not ready.
//   ovf_clr_i  : clears every sticky overflow bit.
//   resp_o     : merged registered response, valid when resp_o.ack=1.
//   full_o[c]  : channel c holds DEPTH entries.
//   ovf_o[c]   : sticky, a response on channel c was dropped.
//
// Output handshake: resp_o.ack is valid, !stall_i is ready. A beat transfers
// on a clock edge where both are high. While valid && !ready, resp_o holds
// every bit and no FIFO is popped. When not valid or ready, the register
// loads the arbiter winner (popping it) or goes idle.
module fta_respbuf_fifo
    import fta_bus_pkg::*;
    import fta_respbuf_fifo_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  fta_cmd_response128_t resp [CHANNELS],
    input  logic                 stall_i,
    input  logic                 ovf_clr_i,
    output fta_cmd_response128_t resp_o,
    output logic [CHANNELS-1:0]  full_o,
    output logic [CHANNELS-1:0]  ovf_o
);
    localparam int GW = $clog2(CHANNELS);
    localparam fta_respbuf_arb_e MODE = fta_respbuf_arb_e'(ARB_MODE[1:0]);

    fta_cmd_response128_t head [CHANNELS];
    logic [CHANNELS-1:0]  empty;
    logic [CHANNELS-1:0]  req;
    logic [CHANNELS-1:0]  cand;
    logic [CHANNELS-1:0]  pop;
    logic [3:0]           min_pri;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        start;
    logic [GW-1:0]        gnt;
    logic                 gnt_vld;
    logic                 load;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        fta_respbuf_fifo_ch #(
            .DEPTH (DEPTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .push    (resp[g].ack),
            .pop     (pop[g]),
            .ovf_clr (ovf_clr_i),
            .din     (resp[g]),
            .dout    (head[g]),
            .empty   (empty[g]),
            .full    (full_o[g]),
            .ovf     (ovf_o[g])
        );
    end

    assign req  = ~empty;
    assign load = !resp_o.ack || !stall_i;

    // Arbiter. Candidates are all non-empty channels, narrowed in field
    // priority mode to those whose head carries the lowest pri. The
    // round-robin search walks the channels starting after last_grant; the
    // downward loop leaves the first hit in search order as the winner.
    always_comb begin
        int idx;
        idx     = 0;
        min_pri = PRI_IDLE;
        for (int c = 0; c < CHANNELS; c++) begin
            if (req[c] && (head[c].pri < min_pri)) begin
                min_pri = head[c].pri;
            end
        end

        cand = req;
        if (MODE == FTA_ARB_PRI) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cand[c] = req[c] && (head[c].pri == min_pri);
            end
        end

        start   = (last_grant == GW'(CHANNELS - 1)) ? '0 : last_grant + 1'b1;
        gnt     = '0;
        gnt_vld = 1'b0;
        if (MODE == FTA_ARB_FIXED) begin
            for (int c = CHANNELS - 1; c >= 0; c--) begin
                if (cand[c]) begin
                    gnt     = GW'(c);
                    gnt_vld = 1'b1;
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                idx = int'(start) + i;
                if (idx >= CHANNELS) begin
                    idx = idx - CHANNELS;
                end
                if (cand[idx]) begin
                    gnt     = GW'(idx);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pop[c] = load && gnt_vld && (gnt == GW'(c));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_o     <= resp_idle();
            last_grant <= GW'(CHANNELS - 1);
        end else if (load) begin
            if (gnt_vld) begin
                resp_o     <= resp_from_entry(head[gnt]);
                last_grant <= gnt;
            end else begin
                resp_o <= resp_idle();
            end
        end
    end

endmodule

// File: tb/tb_fta_respbuf_fifo.sv
`timescale 1ns/1ps
module tb_fta_respbuf_fifo;
    import fta_bus_pkg::*;

    localparam int CHANNELS = 8;
    localparam int DEPTH    = 4;
    localparam int W        = 16;

    // ---------------- clock / reset / signals ----------------
    logic                 clk = 1'b0;
    logic                 rst_n;
    fta_cmd_response128_t resp [CHANNELS];
    logic                 stall_i;
    logic                 ovf_clr_i;
    fta_cmd_response128_t resp_o;
    logic [CHANNELS-1:0]  full_o;
    logic [CHANNELS-1:0]  ovf_o;
    fta_cmd_response128_t resp_o_p;
    logic [CHANNELS-1:0]  full_o_p;
    logic [CHANNELS-1:0]  ovf_o_p;
    logic                 mon_pri;
    fta_cmd_response128_t mon;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fta_respbuf_fifo #(.CHANNELS(CHANNELS), .DEPTH(DEPTH), .ARB_MODE(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp      (resp),
        .stall_i   (stall_i),
        .ovf_clr_i (ovf_clr_i),
        .resp_o    (resp_o),
        .full_o    (full_o),
        .ovf_o     (ovf_o)
    );

    fta_respbuf_fifo #(.CHANNELS(CHANNELS), .DEPTH(DEPTH), .ARB_MODE(2)) u_dut_pri (
        .clk       (clk),
        .rst_n     (rst_n),
        .resp      (resp),
        .stall_i   (stall_i),
        .ovf_clr_i (ovf_clr_i),
        .resp_o    (resp_o_p),
        .full_o    (full_o_p),
        .ovf_o     (ovf_o_p)
    );

    assign mon = mon_pri ? resp_o_p : resp_o;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_tag(input logic [7:0] tid, input logic [7:0] dat);
        return {tid, dat};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic [7:0] tid, input logic [7:0] dat,
                         input logic [3:0] pri);
        resp[c]     = '0;
        resp[c].ack = 1'b1;
        resp[c].cid = 6'(c);
        resp[c].tid = tid;
        resp[c].dat = {120'h0, dat};
        resp[c].pri = pri;
    endtask

    task automatic clear_resp();
        for (int i = 0; i < CHANNELS; i++) begin
            resp[i] = '0;
        end
    endtask

    task automatic do_reset();
        clear_resp();
        stall_i   = 1'b0;
        ovf_clr_i = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_sample();
        logic [W-1:0] e;
        if (mon.ack) begin
            if (exp_q.size() == 0) begin
                check("sb_extra", 192'({mon.tid, mon.dat[7:0]}), 192'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_order", 192'({mon.tid, mon.dat[7:0]}), 192'(e));
            end
        end
    endtask

    // Consume the expected queue; with strict set, once output starts every
    // clock must carry a response.
    task automatic drain(input bit strict, input int budget);
        int  cyc;
        bit  started;
        cyc     = 0;
        started = 1'b0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (strict && started) begin
                check("no_gap", 192'(mon.ack), 192'(1));
            end
            if (mon.ack) begin
                started = 1'b1;
            end
            sb_sample();
            step();
            cyc++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 192'(exp_q.size()), 192'(0));
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        fta_cmd_response128_t e;
        mon_pri   = 1'b0;
        clear_resp();
        stall_i   = 1'b0;
        ovf_clr_i = 1'b0;
        rst_n     = 1'b0;
        step();
        check("rst_ack", 192'(resp_o.ack), 192'(0));
        check("rst_pri", 192'(resp_o.pri), 192'(4'hF));
        check("rst_full", 192'(full_o), 192'(0));
        check("rst_ovf", 192'(ovf_o), 192'(0));
        rst_n = 1'b1;

        // Fill every channel under stall, then reset mid-traffic.
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                drive(c, 8'(k), 8'(c), 4'd0);
            end
            step();
        end
        clear_resp();
        check("fill_full", 192'(full_o), 192'(8'hFF));
        check("fill_ovf", 192'(ovf_o), 192'(8'hFE));
        check("fill_ack", 192'(resp_o.ack), 192'(1));
        #2;
        rst_n = 1'b0;
        #1;
        e     = '0;
        e.pri = 4'hF;
        check("async_rst_resp", 192'(resp_o), 192'(e));
        check("async_rst_full", 192'(full_o), 192'(0));
        check("async_rst_ovf", 192'(ovf_o), 192'(0));
        step();
        rst_n   = 1'b1;
        stall_i = 1'b0;
        step();
        step();
        check("post_rst_idle", 192'(resp_o.ack), 192'(0));

        // Single push, two-clock latency, then idle.
        do_reset();
        drive(3, 8'd5, 8'hA5, 4'd0);
        step();
        clear_resp();
        check("single_lat1", 192'(resp_o.ack), 192'(0));
        step();
        check("single_ack", 192'(resp_o.ack), 192'(1));
        check("single_tid", 192'(resp_o.tid), 192'(5));
        check("single_dat", 192'(resp_o.dat), 192'(128'hA5));
        check("single_cid", 192'(resp_o.cid), 192'(3));
        step();
        check("single_idle_ack", 192'(resp_o.ack), 192'(0));
        check("single_idle_pri", 192'(resp_o.pri), 192'(4'hF));

        // Round-robin bursts.
        do_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            drive(c, 8'(8'h10 + c), 8'(c), 4'd0);
            exp_q.push_back(mk_tag(8'(8'h10 + c), 8'(c)));
        end
        step();
        clear_resp();
        drain(1'b1, 20);
        drive(4, 8'h20, 8'h44, 4'd0);
        exp_q.push_back(mk_tag(8'h20, 8'h44));
        step();
        clear_resp();
        drain(1'b1, 10);
        for (int c = 0; c < CHANNELS; c++) begin
            drive(c, 8'(8'h30 + c), 8'(c), 4'd0);
        end
        for (int k = 5; k < 5 + CHANNELS; k++) begin
            exp_q.push_back(mk_tag(8'(8'h30 + (k % CHANNELS)), 8'(k % CHANNELS)));
        end
        step();
        clear_resp();
        drain(1'b1, 20);

        // Backpressure: resp_o frozen for 3 stalled edges.
        do_reset();
        drive(1, 8'd10, 8'h1A, 4'd0);
        drive(5, 8'd20, 8'h2A, 4'd0);
        step();
        clear_resp();
        drive(1, 8'd11, 8'h1B, 4'd0);
        step();
        clear_resp();
        drive(1, 8'd12, 8'h1C, 4'd0);
        stall_i = 1'b1;
        e       = '0;
        e.ack   = 1'b1;
        e.cid   = 6'd1;
        e.tid   = 8'd10;
        e.dat   = 128'h1A;
        for (int k = 0; k < 3; k++) begin
            step();
            clear_resp();
            check("stall_hold", 192'(resp_o), 192'(e));
        end
        stall_i = 1'b0;
        exp_q.push_back(mk_tag(8'd10, 8'h1A));
        exp_q.push_back(mk_tag(8'd20, 8'h2A));
        exp_q.push_back(mk_tag(8'd11, 8'h1B));
        exp_q.push_back(mk_tag(8'd12, 8'h1C));
        drain(1'b1, 10);

        // Full / overflow on ch2 with the output register held.
        do_reset();
        drive(0, 8'd29, 8'h09, 4'd0);
        step();
        clear_resp();
        step();
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(2, 8'(30 + k), 8'(8'h40 + k), 4'd0);
            step();
            clear_resp();
            if (k == 2) check("full_after3", 192'(full_o[2]), 192'(0));
            if (k == 3) begin
                check("full_after4", 192'(full_o[2]), 192'(1));
                check("ovf_after4", 192'(ovf_o[2]), 192'(0));
            end
        end
        check("ovf_after5", 192'(ovf_o), 192'(8'h04));
        drive(2, 8'd40, 8'h50, 4'd0);
        ovf_clr_i = 1'b1;
        step();
        clear_resp();
        check("ovf_clr_vs_new", 192'(ovf_o[2]), 192'(1));
        step();
        ovf_clr_i = 1'b0;
        check("ovf_cleared", 192'(ovf_o), 192'(0));
        stall_i = 1'b0;
        exp_q.push_back(mk_tag(8'd29, 8'h09));
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk_tag(8'(30 + k), 8'(8'h40 + k)));
        end
        exp_q.push_back(mk_tag(8'd35, 8'h55));
        drive(2, 8'd35, 8'h55, 4'd0);
        sb_sample();
        step();
        clear_resp();
        check("full_pop_push_ovf", 192'(ovf_o[2]), 192'(0));
        check("full_pop_push_full", 192'(full_o[2]), 192'(1));
        drain(1'b1, 10);
        check("drained_full", 192'(full_o), 192'(0));

        // Field priority mode.
        do_reset();
        mon_pri = 1'b1;
        drive(1, 8'd50, 8'h51, 4'd3);
        drive(6, 8'd60, 8'h61, 4'd1);
        exp_q.push_back(mk_tag(8'd60, 8'h61));
        exp_q.push_back(mk_tag(8'd50, 8'h51));
        step();
        clear_resp();
        step();
        check("rr_mode_first", 192'(resp_o.tid), 192'(50));
        check("pri_mode_pri", 192'(resp_o_p.pri), 192'(1));
        drain(1'b1, 10);
        drive(0, 8'd70, 8'h71, 4'd5);
        drive(2, 8'd71, 8'h72, 4'd1);
        drive(4, 8'd72, 8'h73, 4'd1);
        exp_q.push_back(mk_tag(8'd71, 8'h72));
        exp_q.push_back(mk_tag(8'd72, 8'h73));
        exp_q.push_back(mk_tag(8'd70, 8'h71));
        step();
        clear_resp();
        drain(1'b1, 10);
        mon_pri = 1'b0;

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
